// File: rtl/uart_rx_sipo_cfg.sv
// rtl/uart_rx_sipo_cfg.sv - parametrised UART receive deserialiser with parity/stop checking
// Oversampled start detection, mid-bit sampling, one-cycle completion strobe with registered results.
module uart_rx_sipo_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  localparam int FRAME_W    = 1 + DATA_BITS + ((PARITY_MODE != 0) ? 1 : 0) + STOP_BITS
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  input  logic                 data_tx,
  output logic                 active_flag,
  output logic                 recieved_flag,
  output logic [DATA_BITS-1:0] data_out,
  output logic [FRAME_W-1:0]   data_parll,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int SH_W  = FRAME_W - 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_CNT  = 4'(STOP_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [SH_W-1:0]        shreg_q, shreg_d;
  logic                   flag_q, flag_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic [FRAME_W-1:0]     parll_q, parll_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;

  logic rx_s;
  logic sample;
  logic par_xor;

  assign rx_s    = sync2_q;
  assign sample  = (cnt_q == CNT_LAST);
  assign par_xor = ^shreg_q[DATA_BITS:0];

  always_comb begin
    sync1_d    = data_tx;
    sync2_d    = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_ONE;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    flag_d     = 1'b0;
    data_out_d = data_out_q;
    parll_d    = parll_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          shreg_d = {rx_s, shreg_q[SH_W-1:1]};
          cnt_d   = '0;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            state_d   = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          shreg_d   = {rx_s, shreg_q[SH_W-1:1]};
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = STOP;
        end
      end
      STOP: begin
        // bit_idx == STOP_BITS marks the completion cycle after the last stop sample
        if (bit_idx_q == STOP_CNT) begin
          flag_d     = 1'b1;
          data_out_d = shreg_q[DATA_BITS-1:0];
          parll_d    = {shreg_q, 1'b0};
          perr_d     = (PARITY_MODE == 1) ? par_xor :
                       (PARITY_MODE == 2) ? ~par_xor : 1'b0;
          ferr_d     = ~(&shreg_q[SH_W-1 -: STOP_BITS]);
          cnt_d      = '0;
          bit_idx_d  = '0;
          state_d    = IDLE;
        end else if (sample) begin
          shreg_d   = {rx_s, shreg_q[SH_W-1:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      flag_q     <= 1'b0;
      data_out_q <= '0;
      parll_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      flag_q     <= flag_d;
      data_out_q <= data_out_d;
      parll_q    <= parll_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign active_flag   = (state_q != IDLE);
  assign recieved_flag = flag_q;
  assign data_out      = data_out_q;
  assign data_parll    = parll_q;
  assign parity_err    = perr_q;
  assign frame_err     = ferr_q;

endmodule
